// File: rtl/riscv_lsu.sv
// RISC-V load/store unit: computes base+offset, checks size/alignment, runs a
// single memory handshake with timeout, and returns aligned load data to the register file.
module riscv_lsu #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  A3,
  output logic [31:0] WD3,
  output logic        WE3
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITEBACK} state_t;

  state_t        state_q, state_d;
  logic [1:0]    addr_lo_q, addr_lo_d;
  logic [2:0]    funct3_q, funct3_d;
  logic          is_store_q, is_store_d;
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   load_data_q, load_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d, fault_q, fault_d;
  logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_wstrb_q, mem_wstrb_d;
  logic [4:0]    a3_q, a3_d;
  logic [31:0]   wd3_q, wd3_d;
  logic          we3_q, we3_d;

  logic [31:0]   req_addr_s, st_wdata_s, rd_shift_s, rd_aligned_s;
  logic [3:0]    st_strb_s;
  logic          legal_s, misalign_s;

  assign req_addr_s = base + offset;

  // Request decode: legality, alignment and store lane placement
  always_comb begin
    legal_s    = 1'b0;
    misalign_s = 1'b0;
    st_strb_s  = 4'b1111;
    st_wdata_s = store_data;
    case ({is_store, funct3})
      4'b0_000, 4'b0_001, 4'b0_010, 4'b0_100, 4'b0_101,
      4'b1_000, 4'b1_001, 4'b1_010: legal_s = 1'b1;
      default:                      legal_s = 1'b0;
    endcase
    case (funct3[1:0])
      2'b00: begin
        st_strb_s  = 4'b0001 << req_addr_s[1:0];
        st_wdata_s = {4{store_data[7:0]}};
      end
      2'b01: begin
        misalign_s = req_addr_s[0];
        st_strb_s  = req_addr_s[1] ? 4'b1100 : 4'b0011;
        st_wdata_s = {2{store_data[15:0]}};
      end
      2'b10:   misalign_s = |req_addr_s[1:0];
      default: misalign_s = 1'b0;
    endcase
  end

  // Load lane selection and sign/zero extension
  always_comb begin
    rd_shift_s = mem_rdata >> {addr_lo_q, 3'b000};
    case (funct3_q)
      3'b000:  rd_aligned_s = {{24{rd_shift_s[7]}}, rd_shift_s[7:0]};
      3'b001:  rd_aligned_s = {{16{rd_shift_s[15]}}, rd_shift_s[15:0]};
      3'b100:  rd_aligned_s = {24'h000000, rd_shift_s[7:0]};
      3'b101:  rd_aligned_s = {16'h0000, rd_shift_s[15:0]};
      default: rd_aligned_s = rd_shift_s;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    addr_lo_d   = addr_lo_q;
    funct3_d    = funct3_q;
    is_store_d  = is_store_q;
    rd_d        = rd_q;
    load_data_d = load_data_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    done_d      = 1'b0;
    fault_d     = 1'b0;
    a3_d        = 5'd0;
    wd3_d       = 32'd0;
    we3_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_lo_d  = req_addr_s[1:0];
          funct3_d   = funct3;
          is_store_d = is_store;
          rd_d       = rd;
          if (!legal_s || misalign_s) begin
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else begin
            state_d     = ACCESS;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {req_addr_s[31:2], 2'b00};
            mem_wstrb_d = is_store ? st_strb_s : 4'b0000;
            mem_wdata_d = is_store ? st_wdata_s : 32'd0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        // Any exit from ACCESS releases the whole memory interface at once
        if (mem_ack || (cnt_q == CW'(TIMEOUT - 1))) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = 32'd0;
          mem_wdata_d = 32'd0;
          mem_wstrb_d = 4'b0000;
          cnt_d       = '0;
          if (!mem_ack) begin
            state_d = IDLE;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else if (is_store_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d     = WRITEBACK;
            load_data_d = rd_aligned_s;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WRITEBACK: begin
        state_d = IDLE;
        done_d  = 1'b1;
        a3_d    = rd_q;
        wd3_d   = load_data_q;
        we3_d   = (rd_q != 5'd0);
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= IDLE;
      addr_lo_q   <= 2'b00;
      funct3_q    <= 3'b000;
      is_store_q  <= 1'b0;
      rd_q        <= 5'd0;
      load_data_q <= 32'd0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wstrb_q <= 4'b0000;
      a3_q        <= 5'd0;
      wd3_q       <= 32'd0;
      we3_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_lo_q   <= addr_lo_d;
      funct3_q    <= funct3_d;
      is_store_q  <= is_store_d;
      rd_q        <= rd_d;
      load_data_q <= load_data_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      a3_q        <= a3_d;
      wd3_q       <= wd3_d;
      we3_q       <= we3_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign fault     = fault_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign A3        = a3_q;
  assign WD3       = wd3_q;
  assign WE3       = we3_q;
endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu: driver predicts responses from the ISA rules,
// a memory responder and a completion monitor check the DUT independently.
module tb_riscv_lsu;
  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst, start, is_store, mem_ack;
  logic [2:0]  funct3;
  logic [31:0] base, offset, store_data, mem_rdata;
  logic [4:0]  rd;
  logic        busy, done, fault, mem_req, mem_we, WE3;
  logic [31:0] mem_addr, mem_wdata, WD3;
  logic [3:0]  mem_wstrb;
  logic [4:0]  A3;

  riscv_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .srst(srst), .start(start), .is_store(is_store), .funct3(funct3),
    .base(base), .offset(offset), .store_data(store_data), .rd(rd),
    .busy(busy), .done(done), .fault(fault), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .A3(A3), .WD3(WD3), .WE3(WE3)
  );

  typedef struct {
    logic fault; logic we3; logic [4:0] a3; logic [31:0] wd3; int lat; int t0;
  } resp_t;
  typedef struct {
    logic [31:0] addr; logic we; logic [3:0] strb; logic [31:0] wdata; int delay; logic [31:0] rdata;
  } memx_t;

  resp_t resp_q[$];
  memx_t mem_q[$];
  int checks = 0, errors = 0, cyc = 0;
  bit active = 1'b0, acked = 1'b0, ignore_mem = 1'b0, stray_en = 1'b0;
  int cnt_cyc = 0;
  memx_t cur;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: byte-granular view of an RV32 load/store
  function automatic void predict(input bit st, input logic [2:0] f3, input logic [31:0] b,
      input logic [31:0] o, input logic [31:0] sd, input logic [4:0] r, input int dly,
      input logic [31:0] rdat, output resp_t e, output memx_t m, output bit acc);
    logic [31:0] a, v;
    int size, lane;
    bit legal;
    a = b + o;
    size = 1 << f3[1:0];
    lane = int'(a[1:0]);
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e.fault = 1'b1; e.we3 = 1'b0; e.a3 = 5'd0; e.wd3 = 32'd0; e.lat = 1; e.t0 = 0;
    m.addr = {a[31:2], 2'b00}; m.we = st; m.strb = 4'b0000; m.wdata = 32'd0;
    m.delay = dly; m.rdata = rdat;
    acc = 1'b0;
    if (!legal || (lane % size) != 0) return;
    acc = 1'b1;
    if (st) begin
      m.strb = 4'(((1 << size) - 1) << lane);
      for (int i = 0; i < 4; i++) m.wdata[8*i +: 8] = sd[8*(i % size) +: 8];
    end
    if (dly < 0) begin
      e.lat = 1 + TO;
    end else if (st) begin
      e.fault = 1'b0; e.lat = 2 + dly;
    end else begin
      v = rdat >> (8 * lane);
      if (size == 1) begin
        v = v & 32'h0000_00FF;
        if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
      end else if (size == 2) begin
        v = v & 32'h0000_FFFF;
        if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
      end
      e.fault = 1'b0; e.we3 = (r != 5'd0); e.a3 = r; e.wd3 = v; e.lat = 3 + dly;
    end
  endfunction

  // Completion monitor
  always @(negedge clk) begin
    resp_t e;
    if (!srst) begin
      if (done) begin
        if (resp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          e = resp_q.pop_front();
          chk("latency", 32'(cyc - e.t0), 32'(e.lat));
          chk("fault", 32'(fault), 32'(e.fault));
          chk("we3", 32'(WE3), 32'(e.we3));
          chk("busy_at_done", 32'(busy), 32'd0);
          if (e.we3) begin
            chk("a3", 32'(A3), 32'(e.a3));
            chk("wd3", WD3, e.wd3);
          end
        end
      end else begin
        chk("idle_we3_fault", 32'({WE3, fault}), 32'd0);
      end
    end
  end

  // Memory responder: checks the request fields every cycle and acks on schedule
  always @(negedge clk) begin
    if (srst) begin
      active = 1'b0; mem_ack = 1'b0;
    end else begin
      if (!active && mem_req && !ignore_mem) begin
        if (mem_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_mem_req actual=1 expected=0");
        end else begin
          cur = mem_q.pop_front(); active = 1'b1; acked = 1'b0; cnt_cyc = 0;
        end
      end
      if (active) begin
        if (acked) begin
          chk("req_drop_after_ack", 32'(mem_req), 32'd0);
          active = 1'b0; mem_ack = 1'b0;
        end else if (!mem_req) begin
          chk("req_cycles", 32'(cnt_cyc), 32'(cur.delay < 0 ? TO : cur.delay + 1));
          active = 1'b0; mem_ack = 1'b0;
        end else begin
          cnt_cyc++;
          chk("mem_addr", mem_addr, cur.addr);
          chk("mem_we", 32'(mem_we), 32'(cur.we));
          chk("mem_wstrb", 32'(mem_wstrb), 32'(cur.strb));
          if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
          if (cur.delay >= 0 && cnt_cyc == cur.delay + 1) begin
            mem_ack = 1'b1; mem_rdata = cur.rdata; acked = 1'b1;
          end else begin
            mem_ack = 1'b0; mem_rdata = $urandom;
          end
        end
      end else begin
        mem_ack = stray_en & 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while ((busy || active || resp_q.size() != 0 || mem_q.size() != 0) && n < 60);
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL wait_idle_timeout actual=busy expected=idle");
      resp_q.delete(); mem_q.delete();
    end
  endtask

  task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] b,
      input logic [31:0] o, input logic [31:0] sd, input logic [4:0] r, input int dly,
      input logic [31:0] rdat);
    resp_t e; memx_t m; bit acc;
    wait_idle();
    predict(st, f3, b, o, sd, r, dly, rdat, e, m, acc);
    e.t0 = cyc;
    resp_q.push_back(e);
    if (acc) mem_q.push_back(m);
    start = 1'b1; is_store = st; funct3 = f3; base = b; offset = o; store_data = sd; rd = r;
    @(negedge clk); #1;
    start = 1'b0; is_store = 1'($urandom); funct3 = 3'($urandom); base = $urandom;
    offset = $urandom; store_data = $urandom; rd = 5'($urandom);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, 32'({busy, done, fault, mem_req, mem_we, WE3}), 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_strb_a3"}, 32'({mem_wstrb, A3}), 32'd0);
    chk({tag, "_wd3"}, WD3, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, f;
    srst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0; base = 32'd0;
    offset = 32'd0; store_data = 32'd0; rd = 5'd0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    #1 srst = 1'b0;

    issue(1'b0, 3'b000, 32'h100, 32'd3, 32'd0, 5'd5, 0, 32'h80FF_FF00);  // LB
    issue(1'b0, 3'b101, 32'h200, 32'd2, 32'd0, 5'd6, 0, 32'hBEEF_1234);  // LHU
    issue(1'b0, 3'b001, 32'h200, 32'd2, 32'd0, 5'd6, 1, 32'hBEEF_1234);  // LH
    issue(1'b1, 3'b000, 32'h40, 32'd1, 32'h1234_56AB, 5'd9, 0, 32'd0);   // SB
    issue(1'b0, 3'b010, 32'h100, 32'd2, 32'd0, 5'd4, 0, 32'd0);          // LW misaligned
    issue(1'b0, 3'b010, 32'h104, 32'd0, 32'd0, 5'd0, 0, 32'h1111_2222);  // LW rd=0
    issue(1'b0, 3'b010, 32'h108, 32'd0, 32'd0, 5'd8, -1, 32'd0);         // timeout
    issue(1'b1, 3'b010, 32'h10C, 32'd0, 32'hCAFE_F00D, 5'd1, 3, 32'd0);  // ack on last cycle
    issue(1'b1, 3'b011, 32'h10C, 32'd0, 32'd1, 5'd1, 0, 32'd0);          // illegal store

    for (int i = 0; i < 80; i++) begin
      stray_en = 1'($urandom_range(0, 1));
      d = $urandom_range(0, 5);
      if (d == 4) d = -1;
      if (d == 5) d = 0;
      f = $urandom_range(0, 3) == 0 ? $urandom_range(0, 7) : $urandom_range(0, 2) + 4 * $urandom_range(0, 1);
      issue(1'($urandom), 3'(f), $urandom, 32'($urandom_range(0, 63)) - 32'd32,
            $urandom, 5'($urandom), d, $urandom);
    end

    // Reset in the middle of an access
    wait_idle();
    stray_en = 1'b0; ignore_mem = 1'b1;
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; base = 32'h300; offset = 32'd0; rd = 5'd7;
    @(negedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("pre_reset_req", 32'(mem_req), 32'd1);
    #1 srst = 1'b1;
    @(negedge clk);
    check_zero("mid_reset");
    #1 srst = 1'b0; ignore_mem = 1'b0; stray_en = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset_busy", 32'({busy, mem_req}), 32'd0);

    // Reset wins over a simultaneous start
    #1 srst = 1'b1; start = 1'b1;
    @(negedge clk);
    check_zero("reset_prio");
    #1 srst = 1'b0; start = 1'b0;
    stray_en = 1'b0;
    issue(1'b0, 3'b100, 32'h500, 32'd1, 32'd0, 5'd12, 2, 32'h1234_8765);  // LBU after reset
    wait_idle();
    repeat (3) @(negedge clk);
    chk("queues_drained", 32'(resp_q.size() + mem_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
